sigdelay_mt: RTL and testbench
==============================

SIGDELAY_MT -- requirements
Module: sigdelay_mt

Interface
REQ-001 SHALL have parameter A_WIDTH, default 9: buffer address width; depth is 2^A_WIDTH samples.
REQ-002 SHALL have parameter D_WIDTH, default 8: sample width (unsigned).
REQ-003 SHALL have parameter N_TAPS, default 4: number of independent delay taps (1..8).
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  synchronous clear of buffer state.
REQ-007 in_valid  in  1  sample_in is accepted this cycle.
REQ-008 sample_in  in  D_WIDTH  input sample.
REQ-009 delay  in  N_TAPS*A_WIDTH  packed per-tap delay in samples; tap i is at [i*A_WIDTH +: A_WIDTH].
REQ-010 tap_out  out  N_TAPS*D_WIDTH  packed per-tap delayed samples, registered.
REQ-011 out_valid  out  1  tap_out/mix_out updated this cycle.
REQ-012 full  out  1  buffer holds 2^A_WIDTH-1 or more samples.
REQ-013 mix_out  out  D_WIDTH+$clog2(N_TAPS)  unsigned sum of all taps.

Function
REQ-014 SHALL keep a write pointer wr_ptr that increments by 1, mod 2^A_WIDTH, on each accepted sample, and SHALL write sample_in to buffer[wr_ptr].
REQ-015 SHALL sample delay on each accepted sample; a delay change takes effect on the next accepted sample.
REQ-016 For tap i with delay d>0, SHALL read buffer[wr_ptr - d] (mod 2^A_WIDTH) in the accept cycle and register it into tap i.
REQ-017 For tap i with d=0, SHALL register sample_in directly (bypass), so no read-during-write hazard arises.
REQ-018 Latency: out_valid SHALL assert exactly 1 cycle after each accepted sample and SHALL stay low otherwise; tap_out SHALL hold its value between updates.
REQ-019 SHALL keep fill_cnt, incremented per accepted sample and saturating at 2^A_WIDTH-1.
REQ-020 Tap i SHALL output 0 when its delay exceeds fill_cnt as it stands before the current write; otherwise it SHALL output the stored sample.
REQ-021 SHALL have state machine EMPTY (fill_cnt=0), FILLING (0<fill_cnt<max), FULL (fill_cnt=max).
REQ-022 Transitions: EMPTY->FILLING on accept; FILLING->FULL on the accept that reaches max; any state->EMPTY on flush; FULL remains FULL while writes wrap around.
REQ-023 full SHALL be 1 iff state is FULL.
REQ-024 flush SHALL zero wr_ptr, fill_cnt and tap_out, and SHALL deassert out_valid next cycle; buffer contents need not be cleared.
REQ-025 If flush and in_valid are both high in one cycle, flush SHALL win and the sample SHALL be discarded.
REQ-026 mix_out SHALL be the full-width unsigned sum of the registered tap_out values, with no overflow or truncation.

Reset
REQ-027 On rst: wr_ptr=0, fill_cnt=0, state=EMPTY, tap_out=0, out_valid=0, full=0, mix_out=0, applied asynchronously.
REQ-028 Reset during operation SHALL abandon any in-flight output; the first post-reset accept behaves as from EMPTY.

Configuration
REQ-029 Macro SIGDELAY_MIX_EN: when defined, SHALL implement mix_out per REQ-026.
REQ-030 When SIGDELAY_MIX_EN is undefined, the mix_out port SHALL remain, be tied to 0, and no adder logic SHALL be synthesised.

Structure
REQ-031 Shared package sigdelay_pkg SHALL hold the state enum type (EMPTY/FILLING/FULL) and the default parameter constants.
REQ-032 Storage SHALL be a sub-module delay_ram with 1 write port and N_TAPS synchronous read ports, parameterised by A_WIDTH, D_WIDTH and N_TAPS.

Verification
REQ-033 rst, then accept 1,2,3,... with delays {0,1,4,10}: on the output of sample 11, taps = {11,10,7,1}; out_valid pulses 1 cycle after each accept.
REQ-034 Fill guard: delay=5, accept samples 1..5: tap=0 for the first 5 outputs and tap=1 on the 6th sample's output.
REQ-035 Wrap: A_WIDTH=4, delay=15, stream 0..40: full asserts after 15 accepts; tap equals sample-15 across the pointer wrap.
REQ-036 flush+in_valid together mid-stream: sample dropped, next cycle out_valid=0, state EMPTY, and the next accept with delay=3 yields tap=0.
REQ-037 Mix: N_TAPS=4, all taps fed 255 with delay 0: mix_out=1020 with SIGDELAY_MIX_EN, 0 without.
REQ-038 Async rst asserted between clock edges mid-stream: all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/sigdelay_pkg.sv
// sigdelay_pkg: shared state type and default parameters for the multi-tap
// sample delay line.
package sigdelay_pkg;

  localparam int DEF_A_WIDTH = 9;
  localparam int DEF_D_WIDTH = 8;
  localparam int DEF_N_TAPS  = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/delay_ram.sv
// delay_ram: sample buffer with one write port and N_TAPS synchronous read
// ports.
// Each read port has a registered output that updates only when that port
// is enabled, so it holds its value between reads.
// rd_zero forces a port to 0. This is used while the buffer does not yet
// hold a valid sample at the requested depth.
// rd_byp forwards wr_data straight to a port. This gives a zero-delay tap
// without a read-during-write on the same address.
// clr zeroes every port output.
module delay_ram #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8,
  parameter int N_TAPS  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [A_WIDTH-1:0]         wr_addr,
  input  logic [D_WIDTH-1:0]         wr_data,
  input  logic [N_TAPS-1:0]          rd_en,
  input  logic [N_TAPS-1:0]          rd_zero,
  input  logic [N_TAPS-1:0]          rd_byp,
  input  logic [N_TAPS*A_WIDTH-1:0]  rd_addr,
  output logic [N_TAPS*D_WIDTH-1:0]  rd_data
);

  logic [D_WIDTH-1:0]        mem [0:(2**A_WIDTH)-1];
  logic [N_TAPS*D_WIDTH-1:0] rd_data_d, rd_data_q;

  // Storage write; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Next value of each read-port output register.
  always_comb begin
    rd_data_d = rd_data_q;
    if (clr) begin
      rd_data_d = '0;
    end else begin
      for (int i = 0; i < N_TAPS; i++) begin
        if (rd_en[i]) begin
          if (rd_zero[i])     rd_data_d[i*D_WIDTH +: D_WIDTH] = '0;
          else if (rd_byp[i]) rd_data_d[i*D_WIDTH +: D_WIDTH] = wr_data;
          else                rd_data_d[i*D_WIDTH +: D_WIDTH] = mem[rd_addr[i*A_WIDTH +: A_WIDTH]];
        end
      end
    end
  end

  // Read-port output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sigdelay_mt.sv
// sigdelay_mt: multi-tap sample delay line over a circular buffer.
// Define SIGDELAY_MIX_EN to build the mix_out adder.
// Without it, mix_out is tied to 0 and no adder is built.
//
// state   | meaning
// EMPTY   | no samples stored (fill_cnt = 0)
// FILLING | some samples stored, fewer than 2^A_WIDTH-1
// FULL    | fill_cnt saturated at 2^A_WIDTH-1; writes keep wrapping
module sigdelay_mt
  import sigdelay_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int N_TAPS  = DEF_N_TAPS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 in_valid,
  input  logic [D_WIDTH-1:0]                   sample_in,
  input  logic [N_TAPS*A_WIDTH-1:0]            delay,
  output logic [N_TAPS*D_WIDTH-1:0]            tap_out,
  output logic                                 out_valid,
  output logic                                 full,
  output logic [D_WIDTH+$clog2(N_TAPS)-1:0]    mix_out
);

  localparam int                 M_WIDTH  = D_WIDTH + $clog2(N_TAPS);
  localparam logic [A_WIDTH-1:0] FILL_MAX = '1;

  logic                       accept;
  logic [A_WIDTH-1:0]         wr_ptr_d, wr_ptr_q;
  logic [A_WIDTH-1:0]         fill_cnt_d, fill_cnt_q;
  state_t                     state_d, state_q;
  logic                       full_d, full_q;
  logic                       out_valid_d, out_valid_q;
  logic [N_TAPS-1:0]          rd_zero, rd_byp;
  logic [N_TAPS*A_WIDTH-1:0]  rd_addr;

  // Flush has priority, so a sample arriving with flush is dropped.
  assign accept = in_valid & ~flush;

  // Next-state logic for the pointer, fill count and fill state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    state_d     = state_q;
    full_d      = full_q;
    out_valid_d = accept;
    if (flush) begin
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
      state_d    = EMPTY;
      full_d     = 1'b0;
    end else if (accept) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      fill_cnt_d = (fill_cnt_q == FILL_MAX) ? fill_cnt_q : fill_cnt_q + 1'b1;
      state_d    = (fill_cnt_d == FILL_MAX) ? FULL : FILLING;
      full_d     = (state_d == FULL);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      state_q     <= EMPTY;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      state_q     <= state_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Per-tap read address and mode.
  // The fill guard compares against the count before this write.
  always_comb begin
    rd_addr = '0;
    rd_zero = '0;
    rd_byp  = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      rd_addr[i*A_WIDTH +: A_WIDTH] = wr_ptr_q - delay[i*A_WIDTH +: A_WIDTH];
      rd_byp[i]  = (delay[i*A_WIDTH +: A_WIDTH] == '0);
      rd_zero[i] = (delay[i*A_WIDTH +: A_WIDTH] > fill_cnt_q);
    end
  end

  delay_ram #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH),
    .N_TAPS  (N_TAPS)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_en   (accept),
    .wr_addr (wr_ptr_q),
    .wr_data (sample_in),
    .rd_en   ({N_TAPS{accept}}),
    .rd_zero (rd_zero),
    .rd_byp  (rd_byp),
    .rd_addr (rd_addr),
    .rd_data (tap_out)
  );

  assign out_valid = out_valid_q;
  assign full      = full_q;

`ifdef SIGDELAY_MIX_EN
  // Full-width sum of the registered taps.
  always_comb begin
    mix_out = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      mix_out = mix_out + M_WIDTH'(tap_out[i*D_WIDTH +: D_WIDTH]);
    end
  end
`else
  assign mix_out = '0;
`endif

endmodule

// File: tb/tb_sigdelay_mt.sv
// Directed bench for sigdelay_mt.
// It uses a default-parameter instance plus a small A_WIDTH=4 instance for
// the wrap-around case.
module tb_sigdelay_mt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  sample_in = '0;
  logic [35:0] delay = '0;
  logic [31:0] tap_out;
  logic        out_valid;
  logic        full;
  logic [9:0]  mix_out;

  logic        w_flush = 1'b0;
  logic        w_in_valid = 1'b0;
  logic [7:0]  w_sample = '0;
  logic [3:0]  w_delay = '0;
  logic [7:0]  w_tap;
  logic        w_out_valid;
  logic        w_full;
  logic [7:0]  w_mix;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sigdelay_mt dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .sample_in(sample_in), .delay(delay), .tap_out(tap_out),
    .out_valid(out_valid), .full(full), .mix_out(mix_out)
  );

  sigdelay_mt #(.A_WIDTH(4), .D_WIDTH(8), .N_TAPS(1)) dut_w (
    .clk(clk), .rst(rst), .flush(w_flush), .in_valid(w_in_valid),
    .sample_in(w_sample), .delay(w_delay), .tap_out(w_tap),
    .out_valid(w_out_valid), .full(w_full), .mix_out(w_mix)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
    delay = {9'(d3), 9'(d2), 9'(d1), 9'(d0)};
  endtask

  task automatic accept(input int s);
    in_valid  = 1'b1;
    sample_in = 8'(s);
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] tap(input int i);
    return 32'(tap_out[i*8 +: 8]);
  endfunction

  // Expected tap for the k-th sample (1-based) after an empty start.
  function automatic int exp_tap(input int k, input int d);
    if (d == 0)     return k;
    if (d > k - 1)  return 0;
    return k - d;
  endfunction

  initial begin
    int dl [4];
    dl[0] = 0; dl[1] = 1; dl[2] = 4; dl[3] = 10;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_full",      32'(full), 0);
    check("rst_tap_out",   tap_out, 0);
    check("rst_mix",       32'(mix_out), 0);
    rst = 1'b0;
    idle();

    // Stream 1..11 through taps at delays 0,1,4,10.
    set_delays(0, 1, 4, 10);
    for (int k = 1; k <= 11; k++) begin
      accept(k);
      check("stream_out_valid", 32'(out_valid), 1);
      for (int i = 0; i < 4; i++) check($sformatf("stream_k%0d_tap%0d", k, i), tap(i), 32'(exp_tap(k, dl[i])));
    end
    check("s11_tap0", tap(0), 11);
    check("s11_tap1", tap(1), 10);
    check("s11_tap2", tap(2), 7);
    check("s11_tap3", tap(3), 1);
`ifdef SIGDELAY_MIX_EN
    check("s11_mix", 32'(mix_out), 29);
`else
    check("s11_mix", 32'(mix_out), 0);
`endif
    idle();
    check("idle_out_valid", 32'(out_valid), 0);
    check("idle_hold_tap0", tap(0), 11);

    // Fill guard: delay 5 after a flush.
    flush = 1'b1;
    idle();
    flush = 1'b0;
    check("flush_out_valid", 32'(out_valid), 0);
    check("flush_tap_out",   tap_out, 0);
    set_delays(5, 5, 5, 5);
    for (int k = 1; k <= 6; k++) begin
      accept(k);
      check($sformatf("guard_k%0d", k), tap(0), (k == 6) ? 32'd1 : 32'd0);
    end
    accept(7);
    check("guard_k7", tap(0), 2);

    // Flush together with in_valid: sample dropped.
    flush = 1'b1; in_valid = 1'b1; sample_in = 8'd99;
    idle();
    flush = 1'b0; in_valid = 1'b0;
    check("fv_out_valid", 32'(out_valid), 0);
    check("fv_full",      32'(full), 0);
    check("fv_tap_out",   tap_out, 0);
    set_delays(3, 3, 3, 3);
    accept(7);  check("fv_k1", tap(0), 0);
    accept(8);  check("fv_k2", tap(0), 0);
    accept(9);  check("fv_k3", tap(0), 0);
    accept(10); check("fv_k4", tap(0), 7);

    // Mix with all taps at delay 0 and full-scale input.
    set_delays(0, 0, 0, 0);
    accept(255);
    for (int i = 0; i < 4; i++) check($sformatf("mix_tap%0d", i), tap(i), 255);
`ifdef SIGDELAY_MIX_EN
    check("mix_sum", 32'(mix_out), 1020);
`else
    check("mix_sum", 32'(mix_out), 0);
`endif

    // Wrap on the 16-entry instance at delay 15.
    w_delay = 4'd15;
    for (int s = 0; s <= 40; s++) begin
      w_in_valid = 1'b1;
      w_sample   = 8'(s);
      @(posedge clk); #1;
      w_in_valid = 1'b0;
      check($sformatf("wrap_ov_%0d", s),   32'(w_out_valid), 1);
      check($sformatf("wrap_tap_%0d", s),  32'(w_tap), (s < 15) ? 32'd0 : 32'(s - 15));
      check($sformatf("wrap_full_%0d", s), 32'(w_full), (s >= 14) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset between clock edges.
    in_valid = 1'b1; sample_in = 8'd42;
    w_in_valid = 1'b1; w_sample = 8'd41;
    @(posedge clk); #1;
    in_valid = 1'b0; w_in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 1);
    check("pre_rst_w_full",    32'(w_full), 1);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid",   32'(out_valid), 0);
    check("arst_tap_out",     tap_out, 0);
    check("arst_full",        32'(full), 0);
    check("arst_mix",         32'(mix_out), 0);
    check("arst_w_full",      32'(w_full), 0);
    check("arst_w_tap",       32'(w_tap), 0);
    check("arst_w_out_valid", 32'(w_out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // First accept after reset behaves as from empty.
    set_delays(0, 1, 4, 10);
    accept(5);
    check("post_rst_out_valid", 32'(out_valid), 1);
    check("post_rst_tap0",      tap(0), 5);
    check("post_rst_tap1",      tap(1), 0);
    check("post_rst_full",      32'(full), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
